shzumezues24_seq: RTL and testbench
===================================

# shzumezues24_seq

Sequential 24×24-bit unsigned shift-add multiplier controller. It sequences one 24-bit ripple adder, `Mbledhesi24bit`, over 24 add/shift steps and produces a full 48-bit product. It sits beside the ALU datapath as the multi-cycle MUL resource and is driven by the CPU control unit through a start/done handshake.

## Interface
- Parameters: none. The width is fixed at 24, the width of the shared adder.
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `start` in 1: request to multiply; sampled only in IDLE.
- `a` in 24: multiplicand, unsigned; captured on the accept edge.
- `b` in 24: multiplier, unsigned; captured on the accept edge.
- `busy` out 1: high whenever state ≠ IDLE.
- `done` out 1: single-cycle pulse; the product is valid from this cycle on.
- `product_hi` out 24: bits [47:24] of a·b.
- `product_lo` out 24: bits [23:0] of a·b.
- `overflow` out 1: high when product_hi ≠ 0, i.e. the result does not fit in 24 bits.

## Operation
- Internal registers:
  - M[23:0]: multiplicand.
  - A[23:0]: high accumulator.
  - Q[23:0]: multiplier / low product.
  - cnt[4:0]: step count.
  - state.
- The FSM has three states: IDLE, RUN, DONE.
- **IDLE.** If `start`=1 on an edge (the accept edge), load M←a, Q←b, A←0, cnt←0 and go to RUN. Otherwise stay in IDLE.
- **RUN, one step per edge.** The adder computes {c,s} = A + (Q[0] ? M : 0), with carry-in 0. Then {A,Q} ← {c, s, Q[23:1]} (right shift by one with carry in) and cnt←cnt+1.
- **RUN exit.** On the edge where cnt==23 (the 24th step), perform that step and go to DONE. On the same edge, register product_hi←new A, product_lo←new Q, and overflow←(new A ≠ 0).
- **DONE.** `done`=1 for this one cycle, then unconditionally return to IDLE.
- `start` is ignored in RUN and DONE; no queuing. A new request is accepted in the first IDLE cycle after DONE.
- Product outputs and `overflow` change only on the DONE-entry edge. They hold their value through IDLE and through the next operation until its DONE-entry edge.
- Operands `a`/`b` may change freely after the accept edge.
- The adder operand B is gated to 0 when Q[0]=0. The adder always runs, and its carry is used on every step.

## Timing
- Reset values: state=IDLE, busy=0, done=0, product_hi=0, product_lo=0, overflow=0; M, A, Q, cnt all 0.
- Latency: with accept edge E0, `busy` rises after E0. Steps occur at E1..E24. `done` and the new product are visible after E24, and `busy` falls after E25.
- Throughput: one result per 26 cycles when `start` is held high continuously (accept edges at E0, E26, …).
- The zero operands take the same 24 steps; there is no early termination.
- Reset asserted mid-RUN or during DONE aborts immediately: no `done` pulse and the product clears to 0. After deassertion the first edge sees IDLE.
- `start`=1 in the same cycle `reset` deasserts is accepted on the first clock edge after deassertion.

## Structure
- Shared package `cpu24_pkg`: `W=24`, `MUL_STEPS=24`, state encoding (IDLE=2'b00, RUN=2'b01, DONE=2'b10).
- One sub-module: an instance of `Mbledhesi24bit` (a = A, b = gated M, sum/carryout feed the shift). No other arithmetic operators on the datapath besides the cnt increment.

## Test plan
- Reset, then a=3, b=5, pulse start → done after exactly 24 edges post-accept; product_hi=0x000000, product_lo=0x00000F, overflow=0; busy falls the next cycle.
- a=0xFFFFFF, b=0xFFFFFF → product_hi=0xFFFFFE, product_lo=0x000001, overflow=1 (exercises carry into A on every step).
- a=0x800000, b=0x000002 → product_hi=0x000001, product_lo=0x000000, overflow=1; then a=0, b=0x123456 → product 0, overflow=0, still 24 steps.
- Hold start=1 continuously with a=7, b=9 → accept edges 26 cycles apart, each result 0x00003F. Also change a/b mid-RUN → the result is unaffected, and a start pulse inside RUN is ignored.
- Assert reset at step 10 of a=0x00ABCD × b=0x000100 → all outputs 0 immediately and no done pulse. A subsequent run yields product_lo=0xABCD00, product_hi=0.
- Previous product holds unchanged through IDLE and the entire next RUN until its done edge (check with 3×5 then 0xFFFFFF×0xFFFFFF).

Source files
------------

// File: rtl/cpu24_pkg.sv
// Shared constants and types for the 24-bit CPU datapath blocks.
// Holds the operand width, the multiplier step count and the multiplier FSM encoding.
package cpu24_pkg;

    localparam int unsigned W         = 24;
    localparam int unsigned MUL_STEPS = 24;
    localparam int unsigned CNT_W     = 5;

    // cnt value on the edge that performs the final add/shift step
    localparam logic [CNT_W-1:0] MUL_LAST_STEP = CNT_W'(MUL_STEPS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } mul_state_t;

endpackage

// File: rtl/Mbledhesi24bit.sv
// 24-bit ripple-carry adder with carry-in tied to 0.
// Shared by the sequential multiplier; sum and carry-out feed its right shift.
module Mbledhesi24bit
    import cpu24_pkg::*;
(
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         carryout
);

    logic [W:0] c;

    always_comb begin
        c        = '0;
        sum      = '0;
        for (int unsigned i = 0; i < W; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        carryout = c[W];
    end

endmodule

// File: rtl/shzumezues24_seq.sv
// Sequential 24x24 unsigned shift-add multiplier with a start/done handshake.
// One add/shift step per clock through the shared ripple adder; 48-bit result.
module shzumezues24_seq
    import cpu24_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] product_hi,
    output logic [W-1:0] product_lo,
    output logic         overflow
);

    mul_state_t       state;
    mul_state_t       state_next;
    logic [W-1:0]     m_reg;
    logic [W-1:0]     acc;
    logic [W-1:0]     q_reg;
    logic [CNT_W-1:0] cnt;

    logic [W-1:0]     addend;
    logic [W-1:0]     sum;
    logic             carry;
    logic [W-1:0]     acc_next;
    logic [W-1:0]     q_next;
    logic             last_step;

    // Multiplicand gated by the current multiplier LSB; the adder runs every cycle.
    assign addend = q_reg[0] ? m_reg : '0;

    Mbledhesi24bit u_add (
        .a        (acc),
        .b        (addend),
        .sum      (sum),
        .carryout (carry)
    );

    // {A,Q} <= {carry, sum, Q[23:1]}
    assign acc_next  = {carry, sum[W-1:1]};
    assign q_next    = {sum[0], q_reg[W-1:1]};
    assign last_step = (cnt == MUL_LAST_STEP);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_step) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_reg      <= '0;
            acc        <= '0;
            q_reg      <= '0;
            cnt        <= '0;
            product_hi <= '0;
            product_lo <= '0;
            overflow   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        m_reg <= a;
                        q_reg <= b;
                        acc   <= '0;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    q_reg <= q_next;
                    cnt <= cnt + CNT_W'(1);
                    if (last_step) begin
                        product_hi <= acc_next;
                        product_lo <= q_next;
                        overflow   <= |acc_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_shzumezues24_seq.sv
// Self-checking bench for shzumezues24_seq: behavioural model (a*b, cycle phase) plus literal checks.
module tb_shzumezues24_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [23:0] ai = '0;
    logic [23:0] bi = '0;
    logic        busy;
    logic        done;
    logic [23:0] product_hi;
    logic [23:0] product_lo;
    logic        overflow;

    int tests = 0;
    int fails = 0;
    bit noisy = 1'b0;

    shzumezues24_seq dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .a          (ai),
        .b          (bi),
        .busy       (busy),
        .done       (done),
        .product_hi (product_hi),
        .product_lo (product_lo),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Model: mk = edges since accept (-1 when idle); product = a*b latched after 24 steps.
    int          mk = -1;
    logic [23:0] pa = '0;
    logic [23:0] pb = '0;
    logic [47:0] mprod = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mk    = -1;
            mprod = '0;
        end else if (mk < 0) begin
            if (start) begin
                mk = 0;
                pa = ai;
                pb = bi;
            end
        end else begin
            mk++;
            if (mk == 24) mprod = 48'(pa) * 48'(pb);
            else if (mk == 25) mk = -1;
        end
    end

    always @(negedge clk) begin
        chk("busy", {47'd0, busy}, {47'd0, mk >= 0});
        chk("done", {47'd0, done}, {47'd0, mk == 24});
        chk("product", {product_hi, product_lo}, mprod);
        chk("overflow", {47'd0, overflow}, {47'd0, mprod[47:24] != 24'd0});
    end

    // Called right after the accept edge (+2); returns edges until done is visible.
    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge clk); #2;
            n++;
            if (noisy) begin
                ai    = 24'($urandom);
                bi    = 24'($urandom);
                start = (n == 5);
            end
        end while (!done && n < 40);
        start = 1'b0;
        if (!done) chk("done_timeout", 48'd0, 48'd1);
    endtask

    task automatic mul(input logic [23:0] x, input logic [23:0] y,
                       input logic [47:0] expv, input bit expov, input string nm);
        int n;
        ai = x; bi = y; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        chk({nm, "_busy_rise"}, {47'd0, busy}, 48'd1);
        wait_done(n);
        chk({nm, "_lat"}, 48'(n), 48'd24);
        chk({nm, "_prod"}, {product_hi, product_lo}, expv);
        chk({nm, "_ov"}, {47'd0, overflow}, {47'd0, expov});
        @(posedge clk); #2;
        chk({nm, "_busy_fall"}, {47'd0, busy}, 48'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] x, y;
        int n, t, last, cnt;

        #1 reset = 1'b1;
        @(posedge clk); #2;
        @(posedge clk); #2;
        reset = 1'b0;
        chk("rst_busy", {47'd0, busy}, 48'd0);
        chk("rst_done", {47'd0, done}, 48'd0);
        chk("rst_prod", {product_hi, product_lo}, 48'd0);
        chk("rst_ov", {47'd0, overflow}, 48'd0);

        mul(24'd3, 24'd5, 48'h000000_00000F, 1'b0, "m3x5");
        mul(24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE_000001, 1'b1, "mmax");
        mul(24'h800000, 24'h000002, 48'h000001_000000, 1'b1, "mmsb");
        mul(24'h000000, 24'h123456, 48'd0, 1'b0, "mzero");

        // held start: back-to-back results 26 cycles apart
        ai = 24'd7; bi = 24'd9; start = 1'b1;
        t = 0; last = -1; cnt = 0;
        while (cnt < 3 && t < 100) begin
            @(posedge clk); #2;
            t++;
            if (done) begin
                chk("hold_prod", {product_hi, product_lo}, 48'h3F);
                if (last >= 0) chk("hold_period", 48'(t - last), 48'd26);
                last = t;
                cnt++;
            end
        end
        start = 1'b0;
        chk("hold_count", 48'(cnt), 48'd3);
        @(posedge clk); #2;

        // operands and start toggle mid-run must not disturb the result
        noisy = 1'b1;
        mul(24'h000ABC, 24'h000123, 48'(24'h000ABC) * 48'(24'h000123), 1'b0, "noisy");
        noisy = 1'b0;

        // reset at step 10 aborts everything
        ai = 24'h00ABCD; bi = 24'h000100; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (10) begin @(posedge clk); #2; end
        reset = 1'b1;
        #1;
        chk("abort_busy", {47'd0, busy}, 48'd0);
        chk("abort_done", {47'd0, done}, 48'd0);
        chk("abort_prod", {product_hi, product_lo}, 48'd0);
        chk("abort_ov", {47'd0, overflow}, 48'd0);
        #1;
        repeat (2) begin @(posedge clk); #2; end
        reset = 1'b0;
        mul(24'h00ABCD, 24'h000100, 48'h000000_ABCD00, 1'b0, "rerun");

        // start already high as reset deasserts: first edge accepts
        reset = 1'b1; start = 1'b1; ai = 24'd3; bi = 24'd5;
        @(posedge clk); #2;
        reset = 1'b0;
        @(posedge clk); #2;
        start = 1'b0;
        chk("rel_accept", {47'd0, busy}, 48'd1);
        wait_done(n);
        chk("rel_lat", 48'(n), 48'd24);
        chk("rel_prod", {product_hi, product_lo}, 48'hF);
        @(posedge clk); #2;

        // previous product holds through the whole next run
        ai = 24'hFFFFFF; bi = 24'hFFFFFF; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        for (int i = 1; i < 24; i++) begin
            @(posedge clk); #2;
            chk("hold_prev", {product_hi, product_lo}, 48'hF);
        end
        @(posedge clk); #2;
        chk("hold_done", {47'd0, done}, 48'd1);
        chk("hold_new", {product_hi, product_lo}, 48'hFFFFFE_000001);
        @(posedge clk); #2;

        // randomized operands with assorted bit patterns
        for (int k = 0; k < 25; k++) begin
            case ($urandom_range(0, 3))
                0: x = 24'($urandom);
                1: x = 24'hFFFFFF;
                2: x = 24'(1) << $urandom_range(0, 23);
                default: x = 24'($urandom_range(0, 255));
            endcase
            y = 24'($urandom);
            noisy = ($urandom_range(0, 1) == 1);
            mul(x, y, 48'(x) * 48'(y), (48'(x) * 48'(y)) >= 48'h1000000, "rand");
        end
        noisy = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
